// File: rtl/exec_pkg.sv
// exec_pkg: shared run-control definitions.
//   exec_state_e   : run-control state, encodings HOLD=0 RUN=1 STEP=2 HALTED=3 BREAK=4
//   EXEC_STATE_W   : width of the encoded state (3)
//   exec_is_halted : true for HALTED or BREAK
package exec_pkg;

  localparam int unsigned EXEC_STATE_W = 3;

  typedef enum logic [EXEC_STATE_W-1:0] {
    EXEC_HOLD   = 3'd0,
    EXEC_RUN    = 3'd1,
    EXEC_STEP   = 3'd2,
    EXEC_HALTED = 3'd3,
    EXEC_BREAK  = 3'd4
  } exec_state_e;

  function automatic logic exec_is_halted(input exec_state_e s);
    return (s == EXEC_HALTED) || (s == EXEC_BREAK);
  endfunction

endpackage

// File: rtl/exec_retire_counter.sv
// exec_retire_counter: saturating retired-instruction counter.
//   clk   : clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, wins over en
//   en    : count one retire; holds at all-ones
//   count : current count
module exec_retire_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/exec_controller.sv
// exec_controller: run-control sequencer for the single-cycle core.
// Owns the core clock-enable and core reset: power-on reset hold, free-run,
// single-step, HALT-instruction stop, debug stop and optional PC breakpoint.
// Optional feature macro: EXEC_BP_EN (breakpoint compare); when undefined the
// breakpoint ports are present but ignored and BREAK is unreachable.
//   clk_pi / reset_n_pi       : clock, async active-low reset
//   tick_en_pi                : base enable from clock divider
//   pc_pi                     : current PC
//   halt_cmd_pi / rst_cmd_pi  : decoder HALT / RST instruction flags
//   run/step/stop_req_pi      : debug request pulses
//   bp_valid_pi / bp_addr_pi  : breakpoint arm and address
//   cpu_clk_en_po             : enable to PC, regfile, data memory
//   core_reset_po             : active-high reset to PC, regfile, data memory
//   state_po / halted_po      : encoded state, HALTED-or-BREAK flag
//   retired_cnt_po            : saturating retired-instruction count
module exec_controller
  import exec_pkg::*;
#(
  parameter int unsigned PC_WIDTH          = 16,
  parameter int unsigned CNT_WIDTH         = 32,
  parameter int unsigned RESET_HOLD_CYCLES = 4,
  parameter bit          AUTO_RUN          = 1'b1
) (
  input  logic                    clk_pi,
  input  logic                    reset_n_pi,
  input  logic                    tick_en_pi,
  input  logic [PC_WIDTH-1:0]     pc_pi,
  input  logic                    halt_cmd_pi,
  input  logic                    rst_cmd_pi,
  input  logic                    run_req_pi,
  input  logic                    step_req_pi,
  input  logic                    stop_req_pi,
  input  logic                    bp_valid_pi,
  input  logic [PC_WIDTH-1:0]     bp_addr_pi,
  output logic                    cpu_clk_en_po,
  output logic                    core_reset_po,
  output logic [EXEC_STATE_W-1:0] state_po,
  output logic                    halted_po,
  output logic [CNT_WIDTH-1:0]    retired_cnt_po
);

  localparam int unsigned HOLD_W =
    (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD_CYCLES - 1);

  exec_state_e       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              skip_bp;
  logic              bp_hit;
  logic              executing;
  logic              go_hold;
  logic              cnt_clr;

`ifdef EXEC_BP_EN
  assign bp_hit = bp_valid_pi && (pc_pi == bp_addr_pi) && !skip_bp &&
                  (state == EXEC_RUN);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_valid_pi, bp_addr_pi, pc_pi, skip_bp};
  assign bp_hit    = 1'b0;
`endif

  assign executing     = (state == EXEC_RUN) || (state == EXEC_STEP);
  assign cpu_clk_en_po = tick_en_pi && executing && !halt_cmd_pi && !bp_hit;

  // RST instruction taken this clock (lower priority than stop and HALT).
  assign go_hold = executing && rst_cmd_pi && tick_en_pi &&
                   !stop_req_pi && !halt_cmd_pi;

  // Counter clears on the RST edge as well so it reads 0 throughout HOLD.
  assign cnt_clr = (state == EXEC_HOLD) || go_hold;

  assign core_reset_po = (state == EXEC_HOLD);
  assign state_po      = state;
  assign halted_po     = exec_is_halted(state);

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state    <= EXEC_HOLD;
      hold_cnt <= HOLD_LOAD;
      skip_bp  <= 1'b0;
    end else begin
      if (cpu_clk_en_po) begin
        skip_bp <= 1'b0;
      end
      unique case (state)
        EXEC_HOLD: begin
          if (hold_cnt == '0) begin
            state <= AUTO_RUN ? EXEC_RUN : EXEC_HALTED;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        EXEC_RUN: begin
          if (stop_req_pi || halt_cmd_pi) begin
            state <= EXEC_HALTED;
          end else if (go_hold) begin
            state    <= EXEC_HOLD;
            hold_cnt <= HOLD_LOAD;
          end else if (bp_hit) begin
            state <= EXEC_BREAK;
          end
        end
        EXEC_STEP: begin
          if (stop_req_pi || halt_cmd_pi) begin
            state <= EXEC_HALTED;
          end else if (go_hold) begin
            state    <= EXEC_HOLD;
            hold_cnt <= HOLD_LOAD;
          end else if (tick_en_pi) begin
            state <= EXEC_HALTED;
          end
        end
        EXEC_HALTED, EXEC_BREAK: begin
          if (!halt_cmd_pi) begin
            if (step_req_pi) begin
              state   <= EXEC_STEP;
              skip_bp <= 1'b1;
            end else if (run_req_pi) begin
              state   <= EXEC_RUN;
              skip_bp <= 1'b1;
            end
          end
        end
        default: begin
          state    <= EXEC_HOLD;
          hold_cnt <= HOLD_LOAD;
        end
      endcase
    end
  end

  exec_retire_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_retire_cnt (
    .clk   (clk_pi),
    .rst_n (reset_n_pi),
    .clr   (cnt_clr),
    .en    (cpu_clk_en_po),
    .count (retired_cnt_po)
  );

endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: scoreboard bench for exec_controller. A behavioural
// model of the controller plus a trivial datapath PC produces the expected
// outputs for every clock; a negedge monitor compares them with the DUT.
// Honours EXEC_BP_EN the same way as the design.
module tb_exec_controller;

  localparam int PCW     = 16;
  localparam int CNTW    = 4;
  localparam int HOLD    = 4;
  localparam bit AUTO    = 1'b1;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            tick_en = 1'b0;
  logic [PCW-1:0]  pc = '0;
  logic            halt_cmd = 1'b0;
  logic            rst_cmd = 1'b0;
  logic            run_req = 1'b0;
  logic            step_req = 1'b0;
  logic            stop_req = 1'b0;
  logic            bp_valid = 1'b0;
  logic [PCW-1:0]  bp_addr = '0;
  logic            cpu_clk_en;
  logic            core_reset;
  logic [2:0]      state;
  logic            halted;
  logic [CNTW-1:0] retired_cnt;

  exec_controller #(
    .PC_WIDTH          (PCW),
    .CNT_WIDTH         (CNTW),
    .RESET_HOLD_CYCLES (HOLD),
    .AUTO_RUN          (AUTO)
  ) dut (
    .clk_pi         (clk),
    .reset_n_pi     (reset_n),
    .tick_en_pi     (tick_en),
    .pc_pi          (pc),
    .halt_cmd_pi    (halt_cmd),
    .rst_cmd_pi     (rst_cmd),
    .run_req_pi     (run_req),
    .step_req_pi    (step_req),
    .stop_req_pi    (stop_req),
    .bp_valid_pi    (bp_valid),
    .bp_addr_pi     (bp_addr),
    .cpu_clk_en_po  (cpu_clk_en),
    .core_reset_po  (core_reset),
    .state_po       (state),
    .halted_po      (halted),
    .retired_cnt_po (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int en;
    int crst;
    int hlt;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Program image seen by the decoder, indexed by PC.
  bit prog_halt[64];
  bit prog_rst[64];

  // Model state: mode uses the architectural state numbers 0..4.
  int m_mode, m_hold, m_cnt, m_pc;
  bit m_skip;
  int n_mode, n_hold, n_cnt, n_pc;
  bit n_skip;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("state",       int'(state),       mon_e.st);
      chk("cpu_clk_en",  int'(cpu_clk_en),  mon_e.en);
      chk("core_reset",  int'(core_reset),  mon_e.crst);
      chk("halted",      int'(halted),      mon_e.hlt);
      chk("retired_cnt", int'(retired_cnt), mon_e.cnt);
    end
  end

  task automatic load_prog(input int halt_at, input int rst_at, input bit rnd);
    for (int i = 0; i < 64; i++) begin
      prog_halt[i] = rnd ? ($urandom_range(29, 0) == 0) : (i == halt_at);
      prog_rst[i]  = rnd ? ($urandom_range(29, 0) == 0) : (i == rst_at);
    end
  endtask

  // One clock: commit the model, apply inputs, queue the expected outputs,
  // then work out what the model becomes at the next edge.
  task automatic cyc(input bit rn, input bit tk, input bit rr, input bit sr, input bit st);
    exp_t e;
    bit   hc, rc, bph, en;
    @(posedge clk);
    #1;
    m_mode = n_mode; m_hold = n_hold; m_cnt = n_cnt; m_pc = n_pc; m_skip = n_skip;
    reset_n  = rn;
    tick_en  = tk;
    run_req  = rr;
    step_req = sr;
    stop_req = st;
    if (!rn) begin
      m_mode = 0; m_hold = HOLD - 1; m_cnt = 0; m_pc = 0; m_skip = 1'b0;
    end
    hc = prog_halt[m_pc % 64];
    rc = prog_rst[m_pc % 64];
    pc       = PCW'(m_pc);
    halt_cmd = hc;
    rst_cmd  = rc;
`ifdef EXEC_BP_EN
    bph = bp_valid && (m_pc == int'(bp_addr)) && !m_skip && (m_mode == 1);
`else
    bph = 1'b0;
`endif
    en = tk && (m_mode == 1 || m_mode == 2) && !hc && !bph;
    e.st   = m_mode;
    e.en   = int'(en);
    e.crst = int'(m_mode == 0);
    e.hlt  = int'(m_mode == 3 || m_mode == 4);
    e.cnt  = m_cnt;
    sb.push_back(e);

    n_mode = m_mode; n_hold = m_hold; n_cnt = m_cnt; n_pc = m_pc; n_skip = m_skip;
    if (rn) begin
      if (en) begin
        n_skip = 1'b0;
        n_pc   = (m_pc + 1) % 65536;
        if (m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
      end
      if (m_mode == 0) begin
        n_pc  = 0;
        n_cnt = 0;
        if (m_hold == 0) n_mode = AUTO ? 1 : 3;
        else             n_hold = m_hold - 1;
      end else if (m_mode == 1 || m_mode == 2) begin
        if (st || hc) begin
          n_mode = 3;
        end else if (rc && tk) begin
          n_mode = 0; n_hold = HOLD - 1; n_cnt = 0;
        end else if (m_mode == 1 && bph) begin
          n_mode = 4;
        end else if (m_mode == 2 && tk) begin
          n_mode = 3;
        end
      end else if (!hc) begin
        if (sr) begin
          n_mode = 2; n_skip = 1'b1;
        end else if (rr) begin
          n_mode = 1; n_skip = 1'b1;
        end
      end
    end
  endtask

  initial begin
    n_mode = 0; n_hold = HOLD - 1; n_cnt = 0; n_pc = 0; n_skip = 1'b0;

    // Reset release into RUN, HALT at PC 5, run_req ignored under HALT.
    load_prog(5, -1, 1'b0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (16) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);

    // Stop right after the hold, then three single steps on a sparse tick.
    load_prog(-1, -1, 1'b0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) cyc(1, (i % 4) == 3, 0, 0, 0);
    end

    // Breakpoint at 0x0008, then resume past it.
    bp_valid = 1'b1;
    bp_addr  = 16'h0008;
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (20) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    repeat (6) cyc(1, 1, 0, 0, 0);
    bp_valid = 1'b0;

    // RST instruction at PC 3 loops back through the hold; counter saturation.
    load_prog(-1, 3, 1'b0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (20) cyc(1, 1, 0, 0, 0);
    load_prog(-1, -1, 1'b0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (26) cyc(1, 1, 0, 0, 0);

    // stop+run together in RUN, then a reset while a step is pending.
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (6) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 1);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (8) cyc(1, 1, 0, 0, 0);

    // Randomised traffic.
    load_prog(-1, -1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      bit rn;
      rn = ($urandom_range(149, 0) != 0);
      if (!rn && $urandom_range(1, 0) == 1) load_prog(-1, -1, 1'b1);
      if ($urandom_range(49, 0) == 0) begin
        bp_valid = ($urandom_range(2, 0) != 0);
        bp_addr  = PCW'($urandom_range(40, 0));
      end
      cyc(rn,
          $urandom_range(3, 0) != 0,
          $urandom_range(11, 0) == 0,
          $urandom_range(11, 0) == 0,
          $urandom_range(23, 0) == 0);
    end

    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
- Run-control sequencer for the single-cycle processor core.
- Owns the core clock-enable and the core reset. Decides cycle by cycle whether the PC, register file and data memory advance.
- Implements power-on reset hold, free-run, single-step, HALT-instruction stop, debug stop and an optional PC breakpoint.
- Sits between the clock divider, the instruction decoder and the datapath; replaces the ad-hoc `cpu_clk_en && ~halt` gating.

Parameters:
- PC_WIDTH, 16, width of PC and breakpoint address
- CNT_WIDTH, 32, width of retired-instruction counter
- RESET_HOLD_CYCLES, 4, clocks core_reset_po is held after any reset source (min 1)
- AUTO_RUN, 1, 1: enter RUN after reset hold; 0: enter HALTED

Ports:
- clk_pi  in  1  system clock
- reset_n_pi  in  1  asynchronous, active-low reset
- tick_en_pi  in  1  base enable from clock divider
- pc_pi  in  PC_WIDTH  current PC from program counter
- halt_cmd_pi  in  1  decoder: current instruction is HALT
- rst_cmd_pi  in  1  decoder: current instruction is RST
- run_req_pi  in  1  debug: resume, single-cycle pulse
- step_req_pi  in  1  debug: execute one instruction, pulse
- stop_req_pi  in  1  debug: stop, pulse
- bp_valid_pi  in  1  breakpoint armed
- bp_addr_pi  in  PC_WIDTH  breakpoint PC
- cpu_clk_en_po  out  1  enable to PC, regfile, data_mem
- core_reset_po  out  1  active-high reset to PC, regfile, data_mem
- state_po  out  3  encoded state
- halted_po  out  1  state is HALTED or BREAK
- retired_cnt_po  out  CNT_WIDTH  instructions retired

Behaviour:
- States and encodings: HOLD=0, RUN=1, STEP=2, HALTED=3, BREAK=4.
- Async reset (reset_n_pi=0):
  - state=HOLD, hold counter=RESET_HOLD_CYCLES-1, retired_cnt_po=0, skip_bp=0.
  - core_reset_po=1, cpu_clk_en_po=0.
- HOLD:
  - core_reset_po=1; hold counter decrements every clk (not gated by tick_en_pi).
  - At 0: go to RUN if AUTO_RUN else HALTED.
  - core_reset_po therefore spans exactly RESET_HOLD_CYCLES clocks.
  - Debug requests are ignored.
- cpu_clk_en_po = tick_en_pi & (state==RUN | state==STEP) & ~halt_cmd_pi & ~bp_hit, driven combinationally from registered state.
  - bp_hit = bp_valid_pi & (pc_pi==bp_addr_pi) & ~skip_bp & (state==RUN).
  - An instruction retires on each clk where cpu_clk_en_po=1.
- retired_cnt_po: +1 per retire, saturates at all-ones, cleared by any reset source.
- RUN, priority high to low:
  1. stop_req_pi -> HALTED.
  2. halt_cmd_pi -> HALTED; the HALT instruction does not retire.
  3. rst_cmd_pi & tick_en_pi -> HOLD (reloads hold counter); RST retires.
  4. bp_hit -> BREAK; the instruction at bp_addr does not retire.
  - Otherwise stay in RUN.
- STEP:
  - Waits for tick_en_pi, then one retire, then HALTED.
  - If halt_cmd_pi: -> HALTED with no retire.
  - stop_req_pi aborts to HALTED.
  - rst_cmd_pi -> HOLD.
- HALTED / BREAK:
  - step_req_pi -> STEP; run_req_pi -> RUN; both set -> STEP.
  - Both requests are ignored while halt_cmd_pi=1, so a HALT is sticky until reset.
- skip_bp: set on every entry to RUN or STEP from HALTED/BREAK; cleared on the first retire. This guarantees resume past a breakpoint.
- Requests arriving in a state where they have no meaning are dropped, not queued.
- Async reset mid-operation aborts everything, including a STEP in progress.

Optional Feature:
- EXEC_BP_EN defined: breakpoint compare as above.
- Undefined:
  - bp_hit is tied to 0, BREAK is unreachable, and bp_valid_pi/bp_addr_pi are ignored.
  - Ports remain present.

Decomposition:
- Shared package exec_pkg: state encodings (EXEC_HOLD..EXEC_BREAK) and the 3-bit state width constant, also used by the debug/status logic.
- One sub-module, exec_retire_counter: a saturating counter with enable and synchronous clear, plus the async active-low reset.

Test Plan:
- Reset release, AUTO_RUN=1, tick_en=1 -> core_reset_po high exactly 4 clks; state 0 then 1; cpu_clk_en_po=1 on the next clk.
- Run to HALT at PC=0x0005 -> state 3 on the next clk; retired_cnt=5; run_req_pi pulse leaves state 3 and cpu_clk_en_po 0.
- AUTO_RUN=0 -> HALTED; three step_req pulses with tick_en asserted every 4th clk -> exactly 3 retires, PC 0->3, state returns to 3 after each.
- EXEC_BP_EN, bp_addr=0x0008 -> BREAK with PC=0x0008 and retired_cnt=8; run_req -> PC reaches 0x0009 without a re-break.
- RST instruction at PC=0x0003 -> retire; core_reset_po=1 for 4 clks; retired_cnt=0; PC=0; back to RUN.
- stop_req and run_req in the same clk in RUN -> HALTED; reset_n_pi pulse during STEP -> HOLD immediately, with no retire.
